// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the seq_divider coprocessor.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The extra top bit makes the borrow of the subtract its sign bit.
  assign shifted = {rem_i, q_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_i};

  always_comb begin
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
    end else begin
      rem_o = shifted[WIDTH-1:0];
    end
    q_o = {q_i[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/finish handshake and div-by-zero flag.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands (truncating division).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             finish_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] step_rem, step_q;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quot_fix, remd_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .q_i       (q_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;

  always_comb begin
    dvd_mag  = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
    dvs_mag  = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    if (state_q == IDLE && start_i) begin
      neg_q_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      neg_r_d = dividend_i[WIDTH-1];
    end
    // MIN/-1 yields magnitude 2^(WIDTH-1), which reads back as MIN.
    quot_fix = neg_q_q ? -step_q   : step_q;
    remd_fix = neg_r_q ? -step_rem : step_rem;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  always_comb begin
    dvd_mag  = dividend_i;
    dvs_mag  = divisor_i;
    quot_fix = step_q;
    remd_fix = step_rem;
  end
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (divisor_i != '0) ? BUSY : FINISH;
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    busy_o      = (state_q == BUSY);
    finish_o    = (state_q == FINISH);
    div_zero_o  = dz_q;
    quotient_o  = quot_q;
    remainder_o = remd_q;
  end

  // Datapath; result registers only move on the edge into FINISH
  always_comb begin
    rem_d  = rem_q;
    q_d    = q_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    remd_d = remd_q;
    dz_d   = dz_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i != '0) begin
            rem_d  = '0;
            q_d    = dvd_mag;
            dvsr_d = dvs_mag;
            cnt_d  = CW'(WIDTH);
          end else begin
            quot_d = '1;
            remd_d = dividend_i;
            dz_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        q_d   = step_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d = quot_fix;
          remd_d = remd_fix;
          dz_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rem_q  <= '0;
      q_q    <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      remd_q <= '0;
      dz_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      q_q    <= q_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      remd_q <= remd_d;
      dz_q   <= dz_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised scoreboard bench for seq_divider; expected results come from
// plain integer division in a reference model.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, finish, div_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_finish = 0;
  int   n_accepted = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .busy_o      (busy),
    .finish_o    (finish),
    .div_zero_o  (div_zero),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] d);
    exp_t e;
    int   sa, sd;
    e.a = a;
    e.d = d;
    if (d == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sd = int'($signed(d));
`else
      sa = int'({24'd0, a});
      sd = int'({24'd0, d});
`endif
      e.q  = W'(sa / sd);
      e.r  = W'(sa % sd);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on every finish pulse
  always @(negedge clk) begin
    if (finish) begin
      exp_t e;
      n_finish++;
      if (sb.size() == 0) begin
        check("unexpected_finish", 32'(finish), 32'd0);
      end else begin
        e = sb.pop_front();
        $display("op %0d: %0d / %0d -> q=0x%0h r=0x%0h dz=%0b", n_finish, e.a, e.d,
                 quotient, remainder, div_zero);
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_zero", 32'(div_zero), 32'(e.dz));
      end
    end
  end

  // Issue one operation from IDLE; optionally keep start high with junk operands.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] d, input bit noisy);
    exp_t e;
    int   cycles, busy_cnt;
    e = model(a, d);
    sb.push_back(e);
    n_accepted++;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = d;
    @(posedge clk);
    #1;
    start = noisy;
    dividend = W'($urandom);
    divisor = W'($urandom);
    cycles = 0;
    busy_cnt = 0;
    while (!finish && cycles < 4 * W) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    check("latency", 32'(cycles), (d == '0) ? 32'd0 : 32'(W));
    check("busy_cycles", 32'(busy_cnt), (d == '0) ? 32'd0 : 32'(W));
    @(posedge clk);
    #1;
    check("idle_after_finish", {30'd0, busy, finish}, 32'd0);
    check("result_hold", 32'(quotient), 32'(e.q));
  endtask

  initial begin
    logic [W-1:0] ra, rd;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, finish, div_zero, quotient, remainder}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(8'd200, 8'd7, 1'b0);
    run_op(8'd5, 8'd0, 1'b0);
    run_op(8'd9, 8'd3, 1'b0);
    run_op(8'd3, 8'd10, 1'b0);
    run_op(8'd255, 8'd1, 1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd0, 8'd9, 1'b0);
    run_op(8'd200, 8'd7, 1'b1);
`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(8'h9C, 8'd7, 1'b0);
    run_op(8'h80, 8'hFF, 1'b0);
`endif

    // Abort during the 4th BUSY cycle: no finish, outputs back to reset values
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd77;
    divisor = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_abort", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_outputs", {busy, finish, div_zero, quotient, remainder}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 2) @(posedge clk);
    run_op(8'd100, 8'd9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(ra, rd, bit'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("finish_count", 32'(n_finish), 32'(n_accepted));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
